// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-port arbiter and its bench:
// port indices, the one-hot helper and the per-owner handshake state names.
package noc_arb_pkg;

  localparam int PORT_L    = 0;
  localparam int PORT_N    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_S    = 4;
  localparam int MAX_PORTS = 16;

  typedef enum logic [1:0] {IDLE, SETUP, REQ} arb_state_e;

  // Indices at or above n yield an all-zero vector.
  function automatic logic [MAX_PORTS-1:0] onehot(input logic [3:0] idx, input int n);
    logic [MAX_PORTS-1:0] v;
    v = '0;
    if (int'(idx) < n) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter_rr_pick.sv
// Combinational cyclic priority search: first set request at or after start,
// wrapping around. Shared with the input-side allocator.
module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(start) + i;
      if (pos >= N) pos = pos - N;
      pos_idx = pos[IDX_W-1:0];
      if (!found && req[pos_idx]) begin
        found = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Sticky round-robin output-port arbiter with RTS/DCTS handshake to the
// downstream router and an optional per-owner hold limit.
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int MAX_HOLD  = 0,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
  output logic                 rts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 owner_valid,
  output logic [IDX_W-1:0]     owner_idx
);

  localparam int                HOLD_W   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PORTS - 1);

  logic [HOLD_W-1:0]    hold_cnt;
  logic                 stall;
  logic                 hs;
  logic                 starve;
  logic                 found;
  logic [IDX_W-1:0]     start_idx;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_PORTS-1:0] owner_oh;

  assign stall    = rts & ~dcts;
  assign hs       = rts & dcts;
  assign starve   = (MAX_HOLD != 0) && (hold_cnt >= HOLD_MAX);
  assign owner_oh = NUM_PORTS'(onehot(4'(owner_idx), NUM_PORTS));
  assign xbar_sel = owner_valid ? owner_oh : '0;
  assign grant    = (hs && owner_valid) ? owner_oh : '0;

  // A starving owner moves the search one past itself so others get a turn.
  always_comb begin
    start_idx = '0;
    if (owner_valid) begin
      if (starve) start_idx = (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;
      else        start_idx = owner_idx;
    end
  end

  rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .start (start_idx),
    .found (found),
    .idx   (pick_idx)
  );

  // Ownership is frozen while the downstream stalls an outstanding RTS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_valid <= 1'b0;
      owner_idx   <= '0;
      rts         <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      rts <= owner_valid & ~hs;
      if (!stall) begin
        if (found) begin
          if (owner_valid && pick_idx == owner_idx) begin
            if (hs && hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          end else begin
            hold_cnt <= '0;
          end
          owner_valid <= 1'b1;
          owner_idx   <= pick_idx;
        end else begin
          owner_valid <= 1'b0;
          hold_cnt    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench: directed handshake/rotation scenarios on three arbiter
// configurations, then randomized traffic against a rule-level reference model.
module tb_noc_rr_arbiter;
  import noc_arb_pkg::*;

  typedef struct {
    bit valid;
    int owner;
    bit rts;
    int hold;
  } mstate_t;

  typedef struct {
    logic [15:0] grant;
    logic [15:0] xbar;
    logic        rts;
    logic        valid;
    logic [3:0]  idx;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req_a = '0, req_b = '0;
  logic [7:0] req_c = '0;
  logic       dcts_a = 1'b0, dcts_b = 1'b0, dcts_c = 1'b0;
  logic       rts_a, rts_b, rts_c, valid_a, valid_b, valid_c;
  logic [4:0] grant_a, grant_b, xbar_a, xbar_b;
  logic [7:0] grant_c, xbar_c;
  logic [2:0] idx_a, idx_b, idx_c;

  int      checks = 0;
  int      errors = 0;
  int      n_of [3] = '{5, 5, 8};
  int      h_of [3] = '{0, 2, 2};
  mstate_t ms [3];
  int      visits [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  noc_rr_arbiter #(.NUM_PORTS(5), .MAX_HOLD(0)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .dcts(dcts_a), .rts(rts_a), .grant(grant_a),
    .xbar_sel(xbar_a), .owner_valid(valid_a), .owner_idx(idx_a));

  noc_rr_arbiter #(.NUM_PORTS(5), .MAX_HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .dcts(dcts_b), .rts(rts_b), .grant(grant_b),
    .xbar_sel(xbar_b), .owner_valid(valid_b), .owner_idx(idx_b));

  noc_rr_arbiter #(.NUM_PORTS(8), .MAX_HOLD(2)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .dcts(dcts_c), .rts(rts_c), .grant(grant_c),
    .xbar_sel(xbar_c), .owner_valid(valid_c), .owner_idx(idx_c));

  function automatic obs_t getObs(input int i);
    obs_t o;
    case (i)
      0:       o = '{16'(grant_a), 16'(xbar_a), rts_a, valid_a, 4'(idx_a)};
      1:       o = '{16'(grant_b), 16'(xbar_b), rts_b, valid_b, 4'(idx_b)};
      default: o = '{16'(grant_c), 16'(xbar_c), rts_c, valid_c, 4'(idx_c)};
    endcase
    return o;
  endfunction

  function automatic int ohIdx(input logic [15:0] v);
    for (int k = 0; k < 16; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [15:0] bitOf(input int k);
    logic [15:0] one;
    one = 16'd1;
    return one << k;
  endfunction

  // Next state derived directly from the arbitration rules.
  function automatic mstate_t modelNext(input mstate_t s, input logic [15:0] r,
                                        input logic d, input int n, input int maxh);
    mstate_t nx;
    bit      hs, stall, starve, found;
    int      start, pick;
    nx     = s;
    hs     = s.rts && d;
    stall  = s.rts && !d;
    nx.rts = s.valid && !hs;
    if (!stall) begin
      starve = (maxh != 0) && (s.hold >= maxh);
      start  = !s.valid ? 0 : (starve ? (s.owner + 1) % n : s.owner);
      found  = 1'b0;
      pick   = 0;
      for (int k = 0; k < n; k++) begin
        if (!found && r[(start + k) % n]) begin
          found = 1'b1;
          pick  = (start + k) % n;
        end
      end
      if (!found) begin
        nx.valid = 1'b0;
        nx.hold  = 0;
      end else begin
        if (s.valid && pick == s.owner) nx.hold = (hs && s.hold < maxh) ? s.hold + 1 : s.hold;
        else                            nx.hold = 0;
        nx.valid = 1'b1;
        nx.owner = pick;
      end
    end
    return nx;
  endfunction

  task automatic applyStimulus(input int i, input logic [15:0] r, input logic d);
    case (i)
      0:       begin req_a = r[4:0]; dcts_a = d; end
      1:       begin req_b = r[4:0]; dcts_b = d; end
      default: begin req_c = r[7:0]; dcts_c = d; end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkDir(input int i, input string tag, input logic r, input logic [15:0] g,
                          input logic [15:0] x, input logic v, input int idx);
    obs_t o;
    o = getObs(i);
    checkOutput({tag, ".rts"}, 32'(o.rts), 32'(r));
    checkOutput({tag, ".grant"}, 32'(o.grant), 32'(g));
    checkOutput({tag, ".xbar_sel"}, 32'(o.xbar), 32'(x));
    checkOutput({tag, ".owner_valid"}, 32'(o.valid), 32'(v));
    checkOutput({tag, ".owner_idx"}, 32'(o.idx), idx);
  endtask

  task automatic checkModel(input int i, input logic d);
    obs_t        o;
    logic [15:0] g, x;
    o = getObs(i);
    x = ms[i].valid ? bitOf(ms[i].owner) : 16'd0;
    g = (ms[i].valid && ms[i].rts && d) ? bitOf(ms[i].owner) : 16'd0;
    checkOutput($sformatf("rand%0d.rts", i), 32'(o.rts), 32'(ms[i].rts));
    checkOutput($sformatf("rand%0d.grant", i), 32'(o.grant), 32'(g));
    checkOutput($sformatf("rand%0d.xbar_sel", i), 32'(o.xbar), 32'(x));
    checkOutput($sformatf("rand%0d.owner_valid", i), 32'(o.valid), 32'(ms[i].valid));
    checkOutput($sformatf("rand%0d.owner_idx", i), 32'(o.idx), ms[i].owner);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(i, 16'd0, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) checkDir(i, $sformatf("reset%0d", i), 1'b0, 16'd0, 16'd0, 1'b0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) ms[i] = '{1'b0, 0, 1'b0, 0};
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          got;
    int          exp_b [11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0};
    int          exp_c [7]  = '{7, 7, 0, 0, 7, 7, 0};
    logic [15:0] rnd_req [3];
    logic        rnd_dcts [3];
    obs_t        o;
    arb_state_e  st;

    $display("[TB] reset and single request on port E");
    doReset();
    applyStimulus(0, 16'h04, 1'b1);
    #1 checkDir(0, "E0", 1'b0, 16'h00, 16'h00, 1'b0, 0);
    tick(); checkDir(0, "E1", 1'b0, 16'h00, 16'h04, 1'b1, PORT_E);
    tick(); checkDir(0, "E2", 1'b1, 16'h04, 16'h04, 1'b1, PORT_E);
    tick(); checkDir(0, "E3", 1'b0, 16'h00, 16'h04, 1'b1, PORT_E);
    tick(); checkDir(0, "E4", 1'b1, 16'h04, 16'h04, 1'b1, PORT_E);
    applyStimulus(0, 16'h00, 1'b1);
    tick(); tick();
    checkDir(0, "idle", 1'b0, 16'h00, 16'h00, 1'b0, PORT_E);

    $display("[TB] backpressure on owner N");
    applyStimulus(0, 16'h02, 1'b0);
    tick(); checkDir(0, "bp0", 1'b0, 16'h00, 16'h02, 1'b1, PORT_N);
    tick();
    applyStimulus(0, 16'h1F, 1'b0);
    #1 checkDir(0, "bp1", 1'b1, 16'h00, 16'h02, 1'b1, PORT_N);
    for (int k = 0; k < 5; k++) begin
      tick(); checkDir(0, "bp_hold", 1'b1, 16'h00, 16'h02, 1'b1, PORT_N);
    end
    applyStimulus(0, 16'h1F, 1'b1);
    #1 checkDir(0, "bp_release", 1'b1, 16'h02, 16'h02, 1'b1, PORT_N);
    tick();
    applyStimulus(0, 16'h1F, 1'b0);
    #1 checkDir(0, "bp_after", 1'b0, 16'h00, 16'h02, 1'b1, PORT_N);
    tick(); checkDir(0, "bp_rts_again", 1'b1, 16'h00, 16'h02, 1'b1, PORT_N);

    $display("[TB] reset while stalled");
    rst = 1'b1;
    applyStimulus(0, 16'h00, 1'b0);
    #1 checkDir(0, "rst_mid", 1'b0, 16'h00, 16'h00, 1'b0, 0);
    tick();
    rst = 1'b0;

    $display("[TB] rotation from idle and sticky priority");
    applyStimulus(0, 16'h11, 1'b1);
    #1 checkDir(0, "rot0", 1'b0, 16'h00, 16'h00, 1'b0, 0);
    tick(); checkDir(0, "rot1", 1'b0, 16'h00, 16'h01, 1'b1, PORT_L);
    tick(); checkDir(0, "rot2", 1'b1, 16'h01, 16'h01, 1'b1, PORT_L);
    applyStimulus(0, 16'h10, 1'b1);
    #1 checkDir(0, "rot2b", 1'b1, 16'h01, 16'h01, 1'b1, PORT_L);
    tick(); checkDir(0, "rot3", 1'b0, 16'h00, 16'h10, 1'b1, PORT_S);
    tick(); checkDir(0, "rot4", 1'b1, 16'h10, 16'h10, 1'b1, PORT_S);
    applyStimulus(0, 16'h11, 1'b1);
    tick(); checkDir(0, "rot5", 1'b0, 16'h00, 16'h10, 1'b1, PORT_S);
    tick(); checkDir(0, "rot6", 1'b1, 16'h10, 16'h10, 1'b1, PORT_S);

    $display("[TB] hold limit rotation, all ports requesting");
    doReset();
    applyStimulus(1, 16'h1F, 1'b1);
    got = 0;
    for (int k = 0; k < 24; k++) begin
      #1 o = getObs(1);
      if (o.grant != 16'd0) begin
        checkOutput("B_order_onehot", 32'($countones(o.grant)), 32'd1);
        if (got < 11) checkOutput($sformatf("B_order[%0d]", got), ohIdx(o.grant), exp_b[got]);
        got++;
      end
      tick();
    end
    checkOutput("B_order_count", 32'(got >= 11), 32'd1);

    $display("[TB] hold limit with a single requester");
    doReset();
    applyStimulus(1, 16'h02, 1'b1);
    got = 0;
    for (int k = 0; k < 12; k++) begin
      #1 o = getObs(1);
      if (o.grant != 16'd0) begin
        checkOutput("B2_grant", 32'(o.grant), 32'h02);
        got++;
      end
      if (k > 0) checkOutput("B2_owner", 32'(o.idx), PORT_N);
      tick();
    end
    checkOutput("B2_grant_count", got, 5);

    $display("[TB] eight-port wrap from owner 7 to owner 0");
    doReset();
    applyStimulus(2, 16'h80, 1'b1);
    got = 0;
    for (int k = 0; k < 16; k++) begin
      #1 o = getObs(2);
      if (o.grant != 16'd0) begin
        if (got < 7) checkOutput($sformatf("C_order[%0d]", got), ohIdx(o.grant), exp_c[got]);
        got++;
        if (got == 1) applyStimulus(2, 16'h81, 1'b1);
      end
      tick();
    end
    checkOutput("C_order_count", 32'(got >= 7), 32'd1);

    $display("[TB] randomized traffic against reference model");
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        rnd_req[i]  = 16'($urandom) & 16'((1 << n_of[i]) - 1);
        rnd_dcts[i] = ($urandom_range(0, 9) < 6);
        applyStimulus(i, rnd_req[i], rnd_dcts[i]);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        checkModel(i, rnd_dcts[i]);
        st = !ms[i].valid ? IDLE : (ms[i].rts ? REQ : SETUP);
        visits[st]++;
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) ms[i] = modelNext(ms[i], rnd_req[i], rnd_dcts[i], n_of[i], h_of[i]);
      #1;
    end
    $display("[TB] random visits IDLE=%0d SETUP=%0d REQ=%0d", visits[IDLE], visits[SETUP], visits[REQ]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_rr_arbiter.md
Name: noc_rr_arbiter

Overview:
- Parametrised output-port arbiter for the NoC router. Successor of the fixed 5-port L/N/E/W/S arbiter.
- Selects one of NUM_PORTS input requesters using sticky round-robin. Drives the crossbar select and runs the RTS/DCTS handshake to the downstream router.
- Adds an optional MAX_HOLD fairness limit that forces rotation after a number of consecutive transfers from the same owner.
- One instance per router output port.

Parameters:
- NUM_PORTS, 5, number of requesters (index 0=L, 1=N, 2=E, 3=W, 4=S when 5); legal range 2..16.
- MAX_HOLD, 0, maximum consecutive handshakes granted to one owner before rotation is forced; 0 = unlimited.
- IDX_W, $clog2(NUM_PORTS), width of owner index (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NUM_PORTS  per-port request, level.
- dcts  in  1  downstream clear-to-send.
- rts  out  1  request-to-send to downstream, registered.
- grant  out  NUM_PORTS  one-hot grant, combinational.
- xbar_sel  out  NUM_PORTS  one-hot crossbar select; all-zero when idle.
- owner_valid  out  1  an owner is selected, registered.
- owner_idx  out  IDX_W  current owner index, registered.

Behaviour:
- Reset (async, rst=1): owner_valid=0, owner_idx=0, rts=0, hold_cnt=0. Combinationally this gives grant=0 and xbar_sel=0. Reset mid-handshake drops rts immediately; no grant is issued.
- Definitions: stall = rts & ~dcts; hs = rts & dcts.
- Outputs:
  - grant = onehot(owner_idx) when hs & owner_valid, else 0.
  - xbar_sel = onehot(owner_idx) when owner_valid, else 0.
- rts next value:
  - 0 if ~owner_valid.
  - 0 if hs, giving one low cycle after every transfer.
  - 1 otherwise.
  - rts therefore rises the cycle after an owner is established.
- Owner update happens on every clock edge where ~stall. owner is frozen while stall.
- Search start:
  - Idle (~owner_valid): port 0.
  - Owner valid and ~starve: owner_idx (sticky).
  - Owner valid and starve: (owner_idx+1) mod NUM_PORTS.
- Search result:
  - Scan NUM_PORTS positions cyclically from the start index. The first set req becomes the new owner_idx and owner_valid=1.
  - No req set: owner_valid=0 and owner_idx unchanged.
- starve = (MAX_HOLD != 0) & (hold_cnt >= MAX_HOLD).
- hold_cnt (width sized for MAX_HOLD, minimum 1 bit):
  - Cleared when the owner changes or the arbiter goes idle.
  - Otherwise incremented on hs, saturating at MAX_HOLD.
  - If starve and the current owner is the only requester, the wrap-around search re-selects it and hold_cnt stays saturated.
- Owner dropping req while stall: no effect. Once rts is asserted, the transfer completes.
- Owner dropping req while rts=0: the owner may change or go idle on that edge.
- Simultaneous hs and owner change: the grant goes to the old owner in the hs cycle. xbar_sel and owner_idx switch on the next edge.
- Latency: req from idle → owner_valid next edge → rts the edge after that → grant in the same cycle as dcts. Minimum 2 cycles from req to grant.
- FSM per owner: IDLE (owner_valid=0) → SETUP (rts=0) → REQ (rts=1, wait for dcts) → SETUP or IDLE.

Decomposition:
- Shared package noc_arb_pkg holds:
  - port index localparams PORT_L=0, PORT_N=1, PORT_E=2, PORT_W=3, PORT_S=4;
  - function onehot(idx, n);
  - typedef arb_state_e {IDLE, SETUP, REQ}, used by the bench only.
- One natural sub-module, rr_pick. It is purely combinational: inputs req vector and start index; outputs found and index. It is reusable by the input-side allocator.

Test Plan:
- Reset and idle: rst pulse mid-run with req=00000 → rts=0, grant=0, xbar_sel=0 within the same cycle as rst high.
- Single request: req=00100 (E), dcts=1 → owner_idx=2 after 1 edge, rts=1 after 2 edges, grant=00100 that cycle, rts=0 next cycle, and the pattern repeats every 2 cycles.
- Backpressure: owner N, rts=1, dcts=0 for 5 cycles while req changes to 11111 → owner_idx=1 and xbar_sel=00010 hold, grant=0; dcts=1 → grant=00010 exactly once.
- Rotation from idle: req=10001 → owner L first. Drop req[0] after one hs → owner S. Sticky priority confirmed by keeping req[4] high → S retained.
- MAX_HOLD=2, req=11111, dcts=1 → owner 0 gets 2 grants, then owner 1 gets 2, then owner 2, and so on. Order is 0,0,1,1,2,2,3,3,4,4,0.
- MAX_HOLD=2, req=00010 only → owner 1 retained indefinitely with grant every 2 cycles. NUM_PORTS=8 variant: req=10000001 from owner 7 wraps to owner 0 after the hold limit.
